// File: rtl/gray_count_decoder.sv
// Receive side of a gray-coded count bus: synchronizes, decodes to binary and
// classifies each successive value as hold, legal +1 step (with wrap) or illegal jump.
module gray_count_decoder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_pulse,
  output logic             wrap_pulse,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned ACQ_W = 3;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    RESYNC  = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]   sync_q;
  logic [WIDTH-1:0]                    g_s;
  logic [WIDTH-1:0]                    dec;
  logic [WIDTH-1:0]                    bin_inc;
  logic [ACQ_W-1:0]                    acq_q, acq_d;
  logic [WIDTH-1:0]                    bin_d;
  logic                                valid_d;
  logic                                step_d;
  logic                                wrap_d;
  logic                                err_d;
  logic [ERR_W-1:0]                    errc_d;

  // Synchronizer chain; stage 0 captures the asynchronous bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
    end
  end

  assign g_s = sync_q[SYNC_STAGES-1];

  // Gray to binary: each bit is the XOR of all gray bits at or above it.
  always_comb begin
    dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec[i] = ^(g_s >> i);
    end
  end

  assign bin_inc = bin_out + WIDTH'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    bin_d   = bin_out;
    valid_d = bin_valid;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    errc_d  = err_count;

    case (state_q)
      ACQUIRE: begin
        if (acq_q == ACQ_W'(SYNC_STAGES)) begin
          bin_d   = dec;
          valid_d = 1'b1;
          state_d = TRACK;
        end else begin
          acq_d = acq_q + ACQ_W'(1);
        end
      end

      TRACK: begin
        if (dec != bin_out) begin
          bin_d = dec;
          if (dec == bin_inc) begin
            step_d = 1'b1;
            wrap_d = &bin_out;
          end else begin
            valid_d = 1'b0;
            err_d   = 1'b1;
            state_d = RESYNC;
            if (!(&err_count)) begin
              errc_d = err_count + ERR_W'(1);
            end
          end
        end
      end

      RESYNC: begin
        if (dec == bin_out) begin
          valid_d = 1'b1;
          state_d = TRACK;
        end else begin
          bin_d = dec;
        end
      end

      default: begin
        state_d = ACQUIRE;
      end
    endcase
  end

  // State and registered outputs; reset overrides every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACQUIRE;
      acq_q      <= '0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      acq_q      <= acq_d;
      bin_out    <= bin_d;
      bin_valid  <= valid_d;
      step_pulse <= step_d;
      wrap_pulse <= wrap_d;
      err_pulse  <= err_d;
      err_count  <= errc_d;
    end
  end

endmodule

// File: doc/gray_count_decoder.md
Name: gray_count_decoder

Overview:
- Receive end of the gray-coded count bus driven by the clock-divided gray counter.
- Synchronizes the gray word into the local clock domain, decodes it to binary, and tracks successive values.
- Flags legal single steps, wrap-around, and illegal jumps, for monitoring and for binary consumers downstream.

Parameters:
WIDTH, 8, width of gray_in / bin_out
SYNC_STAGES, 2, flop stages on gray_in before decode (legal values 2..4)
ERR_W, 16, width of error counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
gray_in  input  WIDTH  gray-coded count (may be asynchronous to clk)
bin_out  output  WIDTH  decoded binary count, registered
bin_valid  output  1  bin_out is tracked and trustworthy
step_pulse  output  1  one-cycle pulse: count advanced by exactly +1
wrap_pulse  output  1  one-cycle pulse: advance was max -> 0 (step_pulse also high)
err_pulse  output  1  one-cycle pulse: illegal transition detected
err_count  output  ERR_W  saturating count of err_pulse events

Behaviour:
- Reset (reset=1 at an edge) clears all of the following:
  - synchronizer flops, bin_out, bin_valid, all pulses, err_count, and the acquire counter are all 0.
  - FSM goes to ACQUIRE.
  - Reset has priority over everything, including mid-RESYNC and mid-ACQUIRE.
- Synchronizer: gray_in passes through SYNC_STAGES flops; the last stage is g_s.
- Decode is combinational on g_s:
  - b[W-1] = g_s[W-1]
  - b[i] = b[i+1] ^ g_s[i]
  - The result d is registered into bin_out only as defined per state.
- Latency: a gray_in value stable before edge k is reflected on bin_out after edge k+SYNC_STAGES. Pulses are registered and coincide with the bin_out update.
- FSM states:
  - ACQUIRE:
    - Count edges with reset low.
    - Edges 1..SYNC_STAGES only fill the synchronizer; bin_valid=0.
    - At edge SYNC_STAGES+1: bin_out<=d, bin_valid<=1, go to TRACK.
    - No step, wrap or err pulse is ever produced in ACQUIRE.
  - TRACK, evaluated every edge with p = current bin_out:
    - d==p: hold; no pulses.
    - d==p+1 mod 2^WIDTH: bin_out<=d, step_pulse=1. Additionally wrap_pulse=1 if p==2^WIDTH-1 and d==0.
    - Any other d (backward step, skip of more than 1, multi-bit gray change): bin_out<=d, bin_valid<=0, err_pulse=1, err_count increments (saturates at all-ones, no wrap), go to RESYNC.
  - RESYNC:
    - d==bin_out: bin_valid<=1, go to TRACK.
    - d!=bin_out: bin_out<=d, stay in RESYNC, no additional err_pulse.
- Pulses are high for exactly one cycle per event. Back-to-back legal steps on consecutive edges give consecutive step_pulse cycles.
- step_pulse and err_pulse are never high together.
- err_count is not cleared by RESYNC; only reset clears it.

Test Plan:
- Reset, then gray_in=0x02 (bin 3) held → bin_valid=0 for edges 1–2 after reset release, at edge 3 bin_out=0x03 and bin_valid=1, no pulses, err_count=0.
- From bin 3, drive gray 0x06 then 0x07 on consecutive cycles → bin_out 0x04 then 0x05, two consecutive step_pulse cycles, each 2 cycles after its input change.
- Walk gray 0x40 (bin 0x7F) → 0xC0 (bin 0x80) → then 0x80 (bin 0xFF) via legal steps → 0x00 → step_pulse on every step, wrap_pulse only on 0xFF→0x00, err_pulse never.
- Tracking bin 0x05, jump gray_in to 0x0F (bin 0x0A) and hold → err_pulse one cycle, err_count=1, bin_valid=0 for one cycle, then bin_valid=1 with bin_out=0x0A. Then step to gray 0x0E (bin 0x0B) → step_pulse, no error.
- Backward step bin 5→4 (gray 0x07→0x06) → err_pulse, no step_pulse.
- Force err_count near all-ones via 2^ERR_W+3 illegal jumps (or ERR_W reduced to 4, 20 jumps) → err_count sticks at all-ones.
- Assert reset for one edge while in RESYNC → all outputs 0, state ACQUIRE. Re-acquisition takes SYNC_STAGES+1 edges, with no err_pulse during it.
